// File: rtl/sensor_poll_scheduler_pkg.sv
// Shared definitions for the sensor poll scheduler: FSM encoding, default data
// widths and the timer width helper.
package sensor_poll_scheduler_pkg;

  localparam int TEMP_W_DEF = 11;
  localparam int DIST_W_DEF = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TEMP_REQ  = 3'd1;
  localparam logic [2:0] ST_TEMP_WAIT = 3'd2;
  localparam logic [2:0] ST_DIST_REQ  = 3'd3;
  localparam logic [2:0] ST_DIST_WAIT = 3'd4;
  localparam logic [2:0] ST_PUBLISH   = 3'd5;
  localparam logic [2:0] ST_WAIT_TICK = 3'd6;

  // Bits needed to count 0..max-1 over the largest of the cycle constants.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sensor_phase_ctrl.sv
// One sensor phase: level request, rising-edge completion detect, timeout and
// latched result with valid/timeout flags.
module sensor_phase_ctrl #(
  parameter int W       = 11,
  parameter int TMO_CYC = 200_000,
  parameter int TMR_W   = 18
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         clr_i,
  input  logic         rdy_i,
  input  logic [W-1:0] data_i,
  output logic         req_o,
  output logic         fin_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         tmo_o
);

  logic             rdy_q;
  logic             req_q, req_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             done_s, expire_s;

  // A level already high before the request is not a completion.
  assign done_s   = rdy_i & ~rdy_q;
  assign expire_s = (tmr_q == TMR_W'(TMO_CYC - 1));
  assign fin_o    = req_q & (done_s | expire_s);

  // Next-state logic for request, phase timer and latched result.
  always_comb begin
    req_d   = req_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    valid_d = clr_i ? 1'b0 : valid_q;
    tmo_d   = clr_i ? 1'b0 : tmo_q;
    if (start_i) begin
      req_d = 1'b1;
      tmr_d = '0;
    end else if (req_q) begin
      tmr_d = tmr_q + TMR_W'(1);
      if (done_s) begin
        req_d   = 1'b0;
        data_d  = data_i;
        valid_d = 1'b1;
        tmo_d   = 1'b0;
      end else if (expire_s) begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        tmo_d   = 1'b1;
      end else begin
        req_d = 1'b1;
      end
    end else begin
      tmr_d = '0;
    end
  end

  // Phase state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q   <= 1'b0;
      req_q   <= 1'b0;
      tmr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      rdy_q   <= rdy_i;
      req_q   <= req_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_o   = req_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign tmo_o   = tmo_q;

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Periodic round scheduler: temperature read, then distance read, then publish.
// Define SENSOR_POLL_ALARM_EN to build the registered BUZZER_EN alarm comparator.
module sensor_poll_scheduler
  import sensor_poll_scheduler_pkg::*;
#(
  parameter int PERIOD_CYC   = 1_000_000,
  parameter int TEMP_TMO_CYC = 200_000,
  parameter int DIST_TMO_CYC = 500_000,
  parameter int TEMP_W       = TEMP_W_DEF,
  parameter int DIST_W       = DIST_W_DEF
`ifdef SENSOR_POLL_ALARM_EN
  ,
  parameter logic [TEMP_W-1:0] TEMP_HI = 11'd38,
  parameter logic [DIST_W-1:0] DIST_LO = 16'd50
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Enable,
  output logic              LM75A_EN,
  input  logic              Read_temp_ok,
  input  logic [TEMP_W-1:0] Temp_data,
  output logic              CSB_EN,
  input  logic              CSB_done,
  input  logic [DIST_W-1:0] CSB_data,
  output logic [TEMP_W-1:0] Temp_out,
  output logic [DIST_W-1:0] Dist_out,
  output logic              Temp_valid,
  output logic              Dist_valid,
  output logic              Temp_tmo,
  output logic              Dist_tmo,
  output logic              Round_done,
  output logic              BUZZER_EN
);

  localparam int TMR_W = timer_width(PERIOD_CYC, TEMP_TMO_CYC, DIST_TMO_CYC);

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             rdone_q;
  logic             wrap_s, enter_temp_s, t_fin_s, d_fin_s;
  logic [2:0]       next_round_s;

  assign wrap_s       = (cnt_q == TMR_W'(PERIOD_CYC - 1));
  assign next_round_s = Enable ? ST_TEMP_REQ : ST_IDLE;
  assign enter_temp_s = (state_d == ST_TEMP_REQ) && (state_q != ST_TEMP_REQ);

  // Round sequencing, period counter and overrun tracking.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = Enable ? ST_TEMP_REQ : ST_IDLE;
      ST_TEMP_REQ:  state_d = ST_TEMP_WAIT;
      ST_TEMP_WAIT: state_d = t_fin_s ? ST_DIST_REQ : ST_TEMP_WAIT;
      ST_DIST_REQ:  state_d = ST_DIST_WAIT;
      ST_DIST_WAIT: state_d = d_fin_s ? ST_PUBLISH : ST_DIST_WAIT;
      ST_PUBLISH:   state_d = (ovr_q || wrap_s) ? next_round_s : ST_WAIT_TICK;
      ST_WAIT_TICK: state_d = wrap_s ? next_round_s : ST_WAIT_TICK;
      default:      state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TMR_W'(1);
    end

    if (enter_temp_s) begin
      ovr_d = 1'b0;
    end else if (wrap_s && (state_q inside {ST_TEMP_REQ, ST_TEMP_WAIT, ST_DIST_REQ, ST_DIST_WAIT})) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // FSM, period counter and Round_done registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      rdone_q <= (state_d == ST_PUBLISH);
    end
  end

  assign Round_done = rdone_q;

  sensor_phase_ctrl #(
    .W       (TEMP_W),
    .TMO_CYC (TEMP_TMO_CYC),
    .TMR_W   (TMR_W)
  ) u_temp (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .start_i (state_q == ST_TEMP_REQ),
    .clr_i   (enter_temp_s),
    .rdy_i   (Read_temp_ok),
    .data_i  (Temp_data),
    .req_o   (LM75A_EN),
    .fin_o   (t_fin_s),
    .data_o  (Temp_out),
    .valid_o (Temp_valid),
    .tmo_o   (Temp_tmo)
  );

  sensor_phase_ctrl #(
    .W       (DIST_W),
    .TMO_CYC (DIST_TMO_CYC),
    .TMR_W   (TMR_W)
  ) u_dist (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .start_i (state_q == ST_DIST_REQ),
    .clr_i   (enter_temp_s),
    .rdy_i   (CSB_done),
    .data_i  (CSB_data),
    .req_o   (CSB_EN),
    .fin_o   (d_fin_s),
    .data_o  (Dist_out),
    .valid_o (Dist_valid),
    .tmo_o   (Dist_tmo)
  );

`ifdef SENSOR_POLL_ALARM_EN
  logic buzz_q, buzz_d;

  // Alarm decision is taken once per round from the freshly published results.
  always_comb begin
    if (state_q == ST_PUBLISH) begin
      buzz_d = (Temp_valid && (Temp_out > TEMP_HI)) || (Dist_valid && (Dist_out < DIST_LO));
    end else begin
      buzz_d = buzz_q;
    end
  end

  // Alarm output register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      buzz_q <= 1'b0;
    end else begin
      buzz_q <= buzz_d;
    end
  end

  assign BUZZER_EN = buzz_q;
`else
  assign BUZZER_EN = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Self-checking bench for sensor_poll_scheduler: fixed round table, random rounds
// against a behavioural model, and hand sequences for latency, disable and reset.
module tb_sensor_poll_scheduler;

  localparam int PERIOD = 120;
  localparam int TMO_T  = 20;
  localparam int TMO_D  = 30;

  typedef struct {
    int          tk;
    logic [10:0] td;
    bit          stale;
    int          dk;
    logic [15:0] dd;
    logic [10:0] et;
    bit          etv;
    bit          ett;
    logic [15:0] ed;
    bit          edv;
    bit          edt;
    bit          ealarm;
  } vec_t;

  logic        Clk, Rst_n, Enable;
  logic        LM75A_EN, Read_temp_ok, CSB_EN, CSB_done;
  logic [10:0] Temp_data, Temp_out;
  logic [15:0] CSB_data, Dist_out;
  logic        Temp_valid, Dist_valid, Temp_tmo, Dist_tmo, Round_done, BUZZER_EN;

  int          n_pass, n_total, cyc, prev_cyc;
  bit          have_prev;
  logic [10:0] m_temp;
  logic [15:0] m_dist;
  vec_t        tbl[9];

  sensor_poll_scheduler #(
    .PERIOD_CYC   (PERIOD),
    .TEMP_TMO_CYC (TMO_T),
    .DIST_TMO_CYC (TMO_D),
    .TEMP_W       (11),
    .DIST_W       (16)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Enable       (Enable),
    .LM75A_EN     (LM75A_EN),
    .Read_temp_ok (Read_temp_ok),
    .Temp_data    (Temp_data),
    .CSB_EN       (CSB_EN),
    .CSB_done     (CSB_done),
    .CSB_data     (CSB_data),
    .Temp_out     (Temp_out),
    .Dist_out     (Dist_out),
    .Temp_valid   (Temp_valid),
    .Dist_valid   (Dist_valid),
    .Temp_tmo     (Temp_tmo),
    .Dist_tmo     (Dist_tmo),
    .Round_done   (Round_done),
    .BUZZER_EN    (BUZZER_EN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // The two requests must never overlap.
  always @(negedge Clk) begin
    if (Rst_n) begin
      n_total++;
      if (LM75A_EN && CSB_EN) $display("FAIL en_exclusive: got both high, required at most one");
      else n_pass++;
    end
  end

  function automatic bit exp_buzz(input vec_t v);
`ifdef SENSOR_POLL_ALARM_EN
    return v.ealarm;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: a response k cycles into a window of TMO cycles is accepted iff k < TMO.
  function automatic vec_t model_round(input int tk, input logic [10:0] td, input int dk,
                                       input logic [15:0] dd);
    vec_t v;
    bit t_ok, d_ok;
    t_ok = (tk >= 0) && (tk < TMO_T);
    d_ok = (dk >= 0) && (dk < TMO_D);
    v.tk = tk; v.td = td; v.stale = 1'b0; v.dk = dk; v.dd = dd;
    v.et = t_ok ? td : m_temp; v.etv = t_ok; v.ett = !t_ok;
    v.ed = d_ok ? dd : m_dist; v.edv = d_ok; v.edt = !d_ok;
    v.ealarm = (t_ok && (v.et > 11'd38)) || (d_ok && (v.ed < 16'd50));
    return v;
  endfunction

  task automatic run_round(input vec_t v, input string tag);
    int b;
    if (v.stale) Read_temp_ok = 1'b1;
    b = 0;
    while (!LM75A_EN && b < PERIOD + 20) begin @(negedge Clk); b++; end
    check({tag, " temp_req"}, LM75A_EN, 1);
    if (have_prev) check({tag, " period"}, cyc - prev_cyc, PERIOD);
    prev_cyc = cyc; have_prev = 1'b1;
    check({tag, " flags_clr"}, {Temp_valid, Temp_tmo, Dist_valid, Dist_tmo}, 0);
    if (v.tk >= 0) begin
      for (int i = 0; i < v.tk; i++) @(negedge Clk);
      Temp_data = v.td; Read_temp_ok = 1'b1;
    end
    b = 0;
    while (LM75A_EN && b < TMO_T + 5) begin @(negedge Clk); b++; end
    check({tag, " temp_rel"}, LM75A_EN, 0);
    Read_temp_ok = 1'b0;
    b = 0;
    while (!CSB_EN && b < 5) begin @(negedge Clk); b++; end
    check({tag, " csb_req"}, CSB_EN, 1);
    if (v.dk >= 0) begin
      for (int i = 0; i < v.dk; i++) @(negedge Clk);
      CSB_data = v.dd; CSB_done = 1'b1;
    end
    b = 0;
    while (CSB_EN && b < TMO_D + 5) begin @(negedge Clk); b++; end
    check({tag, " csb_rel"}, CSB_EN, 0);
    CSB_done = 1'b0;
    b = 0;
    while (!Round_done && b < 5) begin @(negedge Clk); b++; end
    check({tag, " round_done"}, Round_done, 1);
    check({tag, " temp_out"}, Temp_out, v.et);
    check({tag, " temp_valid"}, Temp_valid, v.etv);
    check({tag, " temp_tmo"}, Temp_tmo, v.ett);
    check({tag, " dist_out"}, Dist_out, v.ed);
    check({tag, " dist_valid"}, Dist_valid, v.edv);
    check({tag, " dist_tmo"}, Dist_tmo, v.edt);
    @(negedge Clk);
    check({tag, " round_done_pulse"}, Round_done, 0);
    check({tag, " buzzer"}, BUZZER_EN, exp_buzz(v));
    m_temp = v.et; m_dist = v.ed;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " en"}, {LM75A_EN, CSB_EN}, 0);
    check({tag, " temp_out"}, Temp_out, 0);
    check({tag, " dist_out"}, Dist_out, 0);
    check({tag, " flags"}, {Temp_valid, Dist_valid, Temp_tmo, Dist_tmo, Round_done, BUZZER_EN}, 0);
  endtask

  task automatic check_latency(input string tag);
    @(negedge Clk);
    check({tag, " lat1"}, LM75A_EN, 0);
    @(negedge Clk);
    check({tag, " lat2"}, LM75A_EN, 1);
  endtask

  initial begin
    vec_t v;
    int   b, r, tk, dk, hi_cnt;
    n_pass = 0; n_total = 0; cyc = 0; prev_cyc = 0; have_prev = 1'b0;
    m_temp = 11'd0; m_dist = 16'd0;
    Rst_n = 1'b0; Enable = 1'b0;
    Read_temp_ok = 1'b0; CSB_done = 1'b0; Temp_data = 11'd0; CSB_data = 16'd0;

    tbl[0] = '{10, 11'd35, 1'b0, 15, 16'd100, 11'd35, 1'b1, 1'b0, 16'd100, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{-1, 11'd99, 1'b0, 5, 16'd200, 11'd35, 1'b0, 1'b1, 16'd200, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{-1, 11'd0, 1'b1, 3, 16'd60, 11'd35, 1'b0, 1'b1, 16'd60, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{0, 11'd22, 1'b0, 29, 16'd30, 11'd22, 1'b1, 1'b0, 16'd30, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{19, 11'd40, 1'b0, -1, 16'd999, 11'd40, 1'b1, 1'b0, 16'd30, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{20, 11'd77, 1'b0, 8, 16'd55, 11'd40, 1'b0, 1'b1, 16'd55, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{5, 11'd40, 1'b0, 5, 16'd100, 11'd40, 1'b1, 1'b0, 16'd100, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{5, 11'd20, 1'b0, 5, 16'd30, 11'd20, 1'b1, 1'b0, 16'd30, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{5, 11'd20, 1'b0, 5, 16'd100, 11'd20, 1'b1, 1'b0, 16'd100, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("idle_no_req", LM75A_EN, 0);

    Enable = 1'b1;
    check_latency("start");

    for (int i = 0; i < 9; i++) run_round(tbl[i], $sformatf("row%0d", i));

    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, TMO_T + 3);
      tk = (r >= TMO_T) ? -1 : r;
      r  = $urandom_range(0, TMO_D + 3);
      dk = (r >= TMO_D) ? -1 : r;
      v  = model_round(tk, 11'($urandom_range(0, 60)), dk, 16'($urandom_range(0, 120)));
      run_round(v, $sformatf("rnd%0d", i));
    end

    // Disable at the round boundary: the scheduler must fall back to idle.
    Enable = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < PERIOD + 10; i++) begin
      @(negedge Clk);
      if (LM75A_EN) hi_cnt++;
    end
    check("disabled_no_req", hi_cnt, 0);
    Enable = 1'b1;
    have_prev = 1'b0;
    check_latency("reenable");
    run_round('{2, 11'd45, 1'b0, 4, 16'd70, 11'd45, 1'b1, 1'b0, 16'd70, 1'b1, 1'b0, 1'b1}, "reen_round");

    // Reset while waiting for the distance reading.
    b = 0;
    while (!LM75A_EN && b < PERIOD + 20) begin @(negedge Clk); b++; end
    check("rst_seq temp_req", LM75A_EN, 1);
    repeat (2) @(negedge Clk);
    Temp_data = 11'd55; Read_temp_ok = 1'b1;
    b = 0;
    while (LM75A_EN && b < TMO_T + 5) begin @(negedge Clk); b++; end
    Read_temp_ok = 1'b0;
    b = 0;
    while (!CSB_EN && b < 5) begin @(negedge Clk); b++; end
    check("rst_seq csb_req", CSB_EN, 1);
    check("rst_seq temp_pre", Temp_out, 55);
    repeat (3) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge Clk);
    Rst_n = 1'b1;
    have_prev = 1'b0;
    m_temp = 11'd0; m_dist = 16'd0;
    check_latency("post_rst");
    run_round('{-1, 11'd0, 1'b0, -1, 16'd0, 11'd0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0}, "post_rst_round");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
Periodic scheduler that sequences the two sensor front-ends in strict alternation: the LM75A temperature reader first, then the ultrasonic (CSB) ranging unit. Each measurement round starts on a programmable period tick. Results are latched into stable registers with valid/timeout flags for the core decision logic (buzzer/alarm path). A sensor that does not respond within its timeout cannot stall the round.

Parameters:
PERIOD_CYC, 1_000_000, clock cycles from the start of one round to the start of the next (50 MHz → 20 ms)
TEMP_TMO_CYC, 200_000, maximum cycles to wait for Read_temp_ok after LM75A_EN rises
DIST_TMO_CYC, 500_000, maximum cycles to wait for CSB_done after CSB_EN rises
TEMP_W, 11, temperature data width
DIST_W, 16, distance data width

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Enable  in  1  run rounds while high; sampled only at the round boundary
LM75A_EN  out  1  level request to the LM75A reader, high while a temperature read is outstanding
Read_temp_ok  in  1  reader completion; its rising edge means done
Temp_data  in  TEMP_W  temperature from the reader, valid on the Read_temp_ok rising edge
CSB_EN  out  1  level request to the ultrasonic ranging unit
CSB_done  in  1  ranging completion; its rising edge means done
CSB_data  in  DIST_W  distance, valid on the CSB_done rising edge
Temp_out  out  TEMP_W  last good temperature
Dist_out  out  DIST_W  last good distance
Temp_valid  out  1  Temp_out updated by a successful read this round
Dist_valid  out  1  Dist_out updated by a successful read this round
Temp_tmo  out  1  temperature read timed out in the last round
Dist_tmo  out  1  distance read timed out in the last round
Round_done  out  1  one-cycle pulse after both phases finish
BUZZER_EN  out  1  alarm output; see Optional Feature

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Rst_n assertion mid-round aborts the round immediately, drops LM75A_EN/CSB_EN and clears the latched data.
- Edge detect: Read_temp_ok and CSB_done are registered once. A "done" event is (current & ~previous).
  - A level that is already high when the request starts is not a completion.
- Shared period counter:
  - Free-runs from 0 to PERIOD_CYC-1 while not in IDLE, then wraps to 0.
  - A separate phase timer is cleared on every state entry.
- FSM states:
  - IDLE: if Enable, go to TEMP_REQ and clear the period counter.
  - TEMP_REQ: LM75A_EN rises; go to TEMP_WAIT next cycle.
  - TEMP_WAIT:
    - On a done event: latch Temp_data into Temp_out, set Temp_valid=1, Temp_tmo=0, drop LM75A_EN, go to DIST_REQ.
    - If the phase timer reaches TEMP_TMO_CYC-1 with no done event: set Temp_tmo=1, Temp_valid=0, keep Temp_out, drop LM75A_EN, go to DIST_REQ.
    - A done event and the timeout in the same cycle count as success.
  - DIST_REQ and DIST_WAIT: same rules with CSB_EN, CSB_done, CSB_data, DIST_TMO_CYC and the Dist_* outputs. Exit goes to PUBLISH.
  - PUBLISH: Round_done=1 for exactly one cycle, then go to WAIT_TICK.
  - WAIT_TICK:
    - When the period counter wraps: go to TEMP_REQ if Enable, else IDLE.
    - If the round overran the period (the wrap happened before PUBLISH), start the next round immediately after PUBLISH.
- Valid and timeout flags for both sensors clear at TEMP_REQ entry. They hold stable from their update point to the next round.
- Minimum latency from Enable rising in IDLE to LM75A_EN high: 2 cycles.
- Done events arriving outside the matching WAIT state are ignored.
- LM75A_EN and CSB_EN are never high at the same time.

Optional Feature:
SENSOR_POLL_ALARM_EN.
- Defined:
  - Adds parameters TEMP_HI (default 11'd38) and DIST_LO (default 16'd50).
  - BUZZER_EN is registered. In PUBLISH it is set to (Temp_valid && Temp_out > TEMP_HI) || (Dist_valid && Dist_out < DIST_LO) and holds until the next PUBLISH.
  - Comparisons are unsigned.
- Undefined: BUZZER_EN is tied to 0 and the comparator logic is absent.

Decomposition:
- Shared package: FSM state encoding (IDLE, TEMP_REQ, TEMP_WAIT, DIST_REQ, DIST_WAIT, PUBLISH, WAIT_TICK), TEMP_W/DIST_W defaults, and the timer width function (clog2 of the largest cycle constant).
- One sub-module is natural: sensor_phase_ctrl, a request/edge-detect/timeout unit instantiated twice (temperature and distance) and driven by a start pulse from the top FSM.

Test Plan:
- Nominal round:
  - Stimulus: Enable=1; Read_temp_ok rises 100 cycles after LM75A_EN with Temp_data=35; CSB_done rises 300 cycles after CSB_EN with CSB_data=100.
  - Response: Temp_out=35, Dist_out=100, both valid=1, Round_done pulses once; the next LM75A_EN rises exactly PERIOD_CYC cycles after the first.
- Temperature timeout:
  - Stimulus: Read_temp_ok held 0.
  - Response: Temp_tmo=1 after TEMP_TMO_CYC; CSB_EN still rises; Temp_out keeps its previous value (35).
- Stale level:
  - Stimulus: Read_temp_ok already high before LM75A_EN rises.
  - Response: no completion; a timeout unless a fresh rising edge occurs.
- Reset mid-round:
  - Stimulus: Rst_n low during DIST_WAIT.
  - Response: all outputs return to 0 asynchronously; after release with Enable=1, a round restarts from TEMP_REQ.
- Simultaneous done and timeout:
  - Stimulus: CSB_done rises on the final timeout cycle with CSB_data=30.
  - Response: Dist_valid=1, Dist_tmo=0, Dist_out=30.
- Alarm (with SENSOR_POLL_ALARM_EN):
  - Stimulus: Temp=40, Dist=100.
  - Response: BUZZER_EN=1 after PUBLISH.
  - Stimulus: next round Temp=20, Dist=30.
  - Response: BUZZER_EN=1 (distance).
  - Stimulus: Temp=20, Dist=100.
  - Response: BUZZER_EN=0.
